// File: rtl/data_recovery_block.sv
// data_recovery_block
// -------------------
// Receive end of the processing-stage byte stream. Each accepted beat is
// un-transformed according to its mode, pushed through a 2-entry skid buffer
// towards the consumer, and folded into a fixed-length frame that reports a
// mod-256 checksum. Beats that cannot be recovered bump a saturating counter.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   valid_in    upstream beat valid
//   ready_in    registered: buffer has room for another beat
//   data_in     transformed byte
//   mode        transform applied upstream (00 bypass, 01 inc, 10 inv, 11 gain)
//   valid_out   recovered beat valid
//   ready_out   downstream accepts
//   data_out    recovered byte (holds last value while buffer is empty)
//   frame_done  one-cycle pulse when a frame completes
//   frame_sum   checksum of the last completed frame
//   err_count   saturating count of unrecoverable beats
//
// Optional build macro:
//   DRB_MODE_LOCK_EN  latch the mode on the first beat of each frame and use it
//                     for the whole frame; a beat arriving with a different mode
//                     counts as an error but is still recovered with the latched
//                     mode. Without it every beat uses its own mode.

module data_recovery_block #(
  parameter int FRAME_LEN = 16,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  output logic             ready_in,
  input  logic [7:0]       data_in,
  input  logic [1:0]       mode,
  output logic             valid_out,
  input  logic             ready_out,
  output logic [7:0]       data_out,
  output logic             frame_done,
  output logic [7:0]       frame_sum,
  output logic [CNT_W-1:0] err_count
);

  localparam int CNT_BITS = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_BITS-1:0] LAST_IDX = CNT_BITS'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DONE
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_BITS-1:0]   count_q, count_d;
  logic [7:0]            sum_q, sum_d;
  logic [7:0]            frameSum_q, frameSum_d;
  logic [CNT_W-1:0]      errCount_q, errCount_d;
  logic                  outValid_q, outValid_d;
  logic [7:0]            outData_q, outData_d;
  logic                  skidValid_q, skidValid_d;
  logic [7:0]            skidData_q, skidData_d;
  logic                  ready_q, ready_d;

  logic                  accept;
  logic                  pop;
  logic                  frameStart;
  logic [1:0]            effMode;
  logic                  modeErr;
  logic [7:0]            recData;
  logic                  gainOdd;
  logic                  errInc;

  assign accept     = valid_in && ready_q;
  assign pop        = outValid_q && ready_out;
  // An accept outside COLLECT is always the first beat of a new frame.
  assign frameStart = (state_q != COLLECT);

`ifdef DRB_MODE_LOCK_EN
  logic [1:0] lockMode_q, lockMode_d;

  // The first beat of a frame uses (and latches) its own mode; later beats use
  // the latched one and flag any disagreement.
  always_comb begin
    effMode    = frameStart ? mode : lockMode_q;
    modeErr    = !frameStart && (mode != lockMode_q);
    lockMode_d = (accept && frameStart) ? mode : lockMode_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lockMode_q <= 2'b00;
    end else begin
      lockMode_q <= lockMode_d;
    end
  end
`else
  always_comb begin
    effMode = mode;
    modeErr = 1'b0;
  end
`endif

  // Undo the upstream transform. Gain shifted left, so an odd byte never came
  // out of it and the beat is counted as unrecoverable.
  always_comb begin
    recData = data_in;
    gainOdd = 1'b0;
    case (effMode)
      2'b00: recData = data_in;
      2'b01: recData = data_in - 8'd1;
      2'b10: recData = ~data_in;
      2'b11: begin
        recData = {1'b0, data_in[7:1]};
        gainOdd = data_in[0];
      end
      default: recData = data_in;
    endcase
  end

  // At most one error per beat, even if a mode mismatch and an odd gain byte
  // coincide.
  always_comb begin
    errInc     = accept && (gainOdd || modeErr);
    errCount_d = errCount_q;
    if (errInc && (errCount_q != {CNT_W{1'b1}})) begin
      errCount_d = errCount_q + CNT_W'(1);
    end
  end

  // Skid buffer as an output register plus one overflow register. The output
  // register refills from the overflow entry first to keep FIFO order; an
  // accept only lands in the overflow entry when the output is stalled.
  always_comb begin
    outValid_d  = outValid_q;
    outData_d   = outData_q;
    skidValid_d = skidValid_q;
    skidData_d  = skidData_q;
    if (!outValid_q || pop) begin
      if (skidValid_q) begin
        outValid_d  = 1'b1;
        outData_d   = skidData_q;
        skidValid_d = accept;
        if (accept) begin
          skidData_d = recData;
        end
      end else begin
        outValid_d = accept;
        if (accept) begin
          outData_d = recData;
        end
      end
    end else if (accept) begin
      skidValid_d = 1'b1;
      skidData_d  = recData;
    end
    ready_d = !(outValid_d && skidValid_d);
  end

  // Frame FSM: counts accepted beats; the accept that completes the frame
  // loads frame_sum so it is visible together with frame_done in DONE.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    sum_d      = sum_q;
    frameSum_d = frameSum_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          state_d = COLLECT;
          count_d = CNT_BITS'(1);
          sum_d   = recData;
        end else begin
          state_d = IDLE;
          count_d = '0;
          sum_d   = 8'd0;
        end
      end
      COLLECT: begin
        if (accept) begin
          if (count_q == LAST_IDX) begin
            state_d    = DONE;
            frameSum_d = sum_q + recData;
            count_d    = '0;
            sum_d      = 8'd0;
          end else begin
            count_d = count_q + CNT_BITS'(1);
            sum_d   = sum_q + recData;
          end
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
        sum_d   = 8'd0;
      end
    endcase
  end

  // All state registers; reset drops buffered beats and any partial frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      sum_q       <= 8'd0;
      frameSum_q  <= 8'd0;
      errCount_q  <= '0;
      outValid_q  <= 1'b0;
      outData_q   <= 8'd0;
      skidValid_q <= 1'b0;
      skidData_q  <= 8'd0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      sum_q       <= sum_d;
      frameSum_q  <= frameSum_d;
      errCount_q  <= errCount_d;
      outValid_q  <= outValid_d;
      outData_q   <= outData_d;
      skidValid_q <= skidValid_d;
      skidData_q  <= skidData_d;
      ready_q     <= ready_d;
    end
  end

  assign ready_in   = ready_q;
  assign valid_out  = outValid_q;
  assign data_out   = outData_q;
  assign frame_done = (state_q == DONE);
  assign frame_sum  = frameSum_q;
  assign err_count  = errCount_q;

endmodule

// File: tb/tb_data_recovery_block.sv
// tb_data_recovery_block
// ----------------------
// Directed self-checking bench for data_recovery_block. A narrow err_count
// (CNT_W=2) is used so saturation is reachable in a few beats.

module tb_data_recovery_block;

  localparam int FRAME_LEN = 16;
  localparam int CNT_W     = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             valid_in;
  logic             ready_in;
  logic [7:0]       data_in;
  logic [1:0]       mode;
  logic             valid_out;
  logic             ready_out;
  logic [7:0]       data_out;
  logic             frame_done;
  logic [7:0]       frame_sum;
  logic [CNT_W-1:0] err_count;

  int testsRun    = 0;
  int testsFailed = 0;

  data_recovery_block #(
    .FRAME_LEN(FRAME_LEN),
    .CNT_W    (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .data_in   (data_in),
    .mode      (mode),
    .valid_out (valid_out),
    .ready_out (ready_out),
    .data_out  (data_out),
    .frame_done(frame_done),
    .frame_sum (frame_sum),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, let the edge happen, then settle 1 time unit
  // so outputs reflect the state after that edge.
  task automatic applyStimulus(input logic v, input logic [1:0] m,
                               input logic [7:0] d, input logic ro);
    valid_in  = v;
    mode      = m;
    data_in   = d;
    ready_out = ro;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    applyStimulus(1'b0, 2'b00, 8'h00, 1'b1);
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    valid_in  = 1'b0;
    mode      = 2'b00;
    data_in   = 8'h00;
    ready_out = 1'b1;

    // Reset values
    applyStimulus(1'b0, 2'b00, 8'h00, 1'b1);
    applyStimulus(1'b0, 2'b00, 8'h00, 1'b1);
    checkOutput("rst_ready_in", ready_in, 1);
    checkOutput("rst_valid_out", valid_out, 0);
    checkOutput("rst_data_out", data_out, 8'h00);
    checkOutput("rst_frame_done", frame_done, 0);
    checkOutput("rst_frame_sum", frame_sum, 8'h00);
    checkOutput("rst_err_count", err_count, 0);
    rst = 1'b0;

    // One full bypass frame 0x00..0x0F, no bubbles, sum 0x78
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 2'b00, 8'(i), 1'b1);
      checkOutput("byp_valid", valid_out, 1);
      checkOutput("byp_data", data_out, i);
      checkOutput("byp_ready", ready_in, 1);
      checkOutput("byp_done", frame_done, (i == 15) ? 1 : 0);
    end
    checkOutput("byp_sum", frame_sum, 8'h78);
    applyStimulus(1'b0, 2'b00, 8'h00, 1'b1);
    checkOutput("byp_done_clr", frame_done, 0);
    checkOutput("byp_idle_valid", valid_out, 0);
    checkOutput("byp_hold_data", data_out, 8'h0F);
    checkOutput("byp_sum_hold", frame_sum, 8'h78);
    checkOutput("byp_err", err_count, 0);

    // Inc mode, including 0x00 wrapping to 0xFF
    pulseReset();
    applyStimulus(1'b1, 2'b01, 8'h00, 1'b1);
    checkOutput("inc_00", data_out, 8'hFF);
    applyStimulus(1'b1, 2'b01, 8'h01, 1'b1);
    checkOutput("inc_01", data_out, 8'h00);
    applyStimulus(1'b1, 2'b01, 8'hFF, 1'b1);
    checkOutput("inc_FF", data_out, 8'hFE);
    checkOutput("inc_err", err_count, 0);

    // Inv then gain; odd gain byte is an error
    pulseReset();
    applyStimulus(1'b1, 2'b10, 8'hA5, 1'b1);
    checkOutput("inv_A5", data_out, 8'h5A);
    pulseReset();
    applyStimulus(1'b1, 2'b11, 8'h84, 1'b1);
    checkOutput("gain_84", data_out, 8'h42);
    checkOutput("gain_84_err", err_count, 0);
    applyStimulus(1'b1, 2'b11, 8'h85, 1'b1);
    checkOutput("gain_85", data_out, 8'h42);
    checkOutput("gain_85_err", err_count, 1);

    // Downstream stall: two beats fit, then back-pressure, then drain in order
    pulseReset();
    applyStimulus(1'b1, 2'b00, 8'h10, 1'b0);
    checkOutput("stall_v0", valid_out, 1);
    checkOutput("stall_d0", data_out, 8'h10);
    checkOutput("stall_r0", ready_in, 1);
    applyStimulus(1'b1, 2'b00, 8'h11, 1'b0);
    checkOutput("stall_d1", data_out, 8'h10);
    checkOutput("stall_r1", ready_in, 0);
    applyStimulus(1'b1, 2'b00, 8'h12, 1'b0);
    checkOutput("stall_d2", data_out, 8'h10);
    checkOutput("stall_v2", valid_out, 1);
    checkOutput("stall_r2", ready_in, 0);
    applyStimulus(1'b1, 2'b00, 8'h12, 1'b0);
    checkOutput("stall_d3", data_out, 8'h10);
    checkOutput("stall_r3", ready_in, 0);
    applyStimulus(1'b1, 2'b00, 8'h12, 1'b1);
    checkOutput("drain_d11", data_out, 8'h11);
    checkOutput("drain_r", ready_in, 1);
    applyStimulus(1'b1, 2'b00, 8'h12, 1'b1);
    checkOutput("drain_d12", data_out, 8'h12);
    applyStimulus(1'b1, 2'b00, 8'h13, 1'b1);
    checkOutput("drain_d13", data_out, 8'h13);
    applyStimulus(1'b0, 2'b00, 8'h00, 1'b1);
    checkOutput("drain_empty", valid_out, 0);
    checkOutput("drain_hold", data_out, 8'h13);

    // Back-to-back frames: 0..15 (sum 0x78) then 0,2,..,30 (sum 0xF0)
    pulseReset();
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b1, 2'b00, (i < 16) ? 8'(i) : 8'(2 * (i - 16)), 1'b1);
      checkOutput("b2b_data", data_out, (i < 16) ? i : 2 * (i - 16));
      checkOutput("b2b_valid", valid_out, 1);
      checkOutput("b2b_done", frame_done, (i == 15 || i == 31) ? 1 : 0);
      if (i == 15) checkOutput("b2b_sum1", frame_sum, 8'h78);
      if (i == 20) checkOutput("b2b_sum1_hold", frame_sum, 8'h78);
      if (i == 31) checkOutput("b2b_sum2", frame_sum, 8'hF0);
    end
    applyStimulus(1'b0, 2'b00, 8'h00, 1'b1);
    checkOutput("b2b_done_clr", frame_done, 0);

    // Reset after 5 accepted beats with 2 held in the buffer
    applyStimulus(1'b1, 2'b00, 8'hA0, 1'b1);
    applyStimulus(1'b1, 2'b00, 8'hA1, 1'b1);
    applyStimulus(1'b1, 2'b00, 8'hA2, 1'b1);
    applyStimulus(1'b1, 2'b00, 8'hA3, 1'b1);
    applyStimulus(1'b1, 2'b00, 8'hA4, 1'b0);
    checkOutput("mid_data", data_out, 8'hA3);
    checkOutput("mid_full", ready_in, 0);
    rst = 1'b1;
    applyStimulus(1'b0, 2'b00, 8'h00, 1'b0);
    rst = 1'b0;
    checkOutput("mid_rst_valid", valid_out, 0);
    checkOutput("mid_rst_ready", ready_in, 1);
    checkOutput("mid_rst_data", data_out, 8'h00);
    checkOutput("mid_rst_done", frame_done, 0);
    checkOutput("mid_rst_sum", frame_sum, 8'h00);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 2'b00, 8'(i + 1), 1'b1);
      checkOutput("fresh_data", data_out, i + 1);
      checkOutput("fresh_done", frame_done, (i == 15) ? 1 : 0);
    end
    checkOutput("fresh_sum", frame_sum, 8'h88);

    // err_count saturates at all-ones (CNT_W=2 -> 3)
    applyStimulus(1'b1, 2'b11, 8'h01, 1'b1);
    checkOutput("sat_1", err_count, 1);
    checkOutput("sat_data", data_out, 8'h00);
    applyStimulus(1'b1, 2'b11, 8'h01, 1'b1);
    checkOutput("sat_2", err_count, 2);
    applyStimulus(1'b1, 2'b11, 8'h01, 1'b1);
    checkOutput("sat_3", err_count, 3);
    applyStimulus(1'b1, 2'b11, 8'h01, 1'b1);
    checkOutput("sat_hold", err_count, 3);

    // Mode change inside a frame
    pulseReset();
    applyStimulus(1'b1, 2'b00, 8'h10, 1'b1);
    checkOutput("lock_first", data_out, 8'h10);
    checkOutput("lock_first_err", err_count, 0);
    applyStimulus(1'b1, 2'b10, 8'h10, 1'b1);
`ifdef DRB_MODE_LOCK_EN
    checkOutput("lock_inv_data", data_out, 8'h10);
    checkOutput("lock_inv_err", err_count, 1);
`else
    checkOutput("perbeat_inv_data", data_out, 8'hEF);
    checkOutput("perbeat_inv_err", err_count, 0);
`endif
    applyStimulus(1'b1, 2'b11, 8'h11, 1'b1);
`ifdef DRB_MODE_LOCK_EN
    checkOutput("lock_gain_data", data_out, 8'h11);
    checkOutput("lock_gain_err", err_count, 2);
`else
    checkOutput("perbeat_gain_data", data_out, 8'h08);
    checkOutput("perbeat_gain_err", err_count, 1);
`endif
    applyStimulus(1'b0, 2'b00, 8'h00, 1'b1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
